// File: rtl/div_pkg.sv
// Shared types and default widths for the sequential restoring divider.
// The optional divide-by-zero shortcut (SEQ_DIVIDER_DIV_ZERO_CHECK_EN) is handled in seq_divider.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int DEF_DIVIDEND_W = 8;
   localparam int DEF_DIVISOR_W  = 4;
   localparam int DEF_CNT_W      = $clog2(DEF_DIVIDEND_W + 1);

   // Counter must be able to hold the full iteration count DIVIDEND_W.
   function automatic int cnt_width(input int dividend_w);
      return $clog2(dividend_w + 1);
   endfunction

endpackage

// File: rtl/div_controller.sv
// Control FSM for seq_divider: IDLE/ITER/DONE sequencing, step counter and datapath strobes.
// The divide-by-zero shortcut is requested through dz_req (driven only when SEQ_DIVIDER_DIV_ZERO_CHECK_EN is defined).
module div_controller
   import div_pkg::*;
#(
   parameter int DIVIDEND_W = DEF_DIVIDEND_W
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic enable,
   input  logic dz_req,
   input  logic fits,
   output logic busy,
   output logic done,
   output logic load,
   output logic load_dz,
   output logic shift,
   output logic sub
);

   localparam int CNT_W = cnt_width(DIVIDEND_W);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIVIDEND_W - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             accept;

   always_comb begin
      accept = enable && start && (state_q != ITER);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      load    = 1'b0;
      load_dz = 1'b0;
      shift   = 1'b0;
      sub     = 1'b0;
      busy    = (state_q == ITER);
      done    = (state_q == DONE);

      case (state_q)
         ITER: begin
            if (enable) begin
               shift = 1'b1;
               sub   = fits;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LAST_STEP) begin
                  state_d = DONE;
               end
            end
         end
         default: begin
            if (accept) begin
               cnt_d = '0;
               if (dz_req) begin
                  load_dz = 1'b1;
                  state_d = DONE;
               end else begin
                  load    = 1'b1;
                  state_d = ITER;
               end
            end else if (enable && (state_q == DONE)) begin
               state_d = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per enabled clock, DIVIDEND_W steps per division.
// Define SEQ_DIVIDER_DIV_ZERO_CHECK_EN to finish a zero-divisor division on the accepting edge with div_zero=1.
module seq_divider
   import div_pkg::*;
#(
   parameter int DIVIDEND_W = DEF_DIVIDEND_W,
   parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  enable,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic                  busy,
   output logic                  done,
   output logic [DIVIDEND_W-1:0] quotient,
   output logic [DIVISOR_W-1:0]  remainder,
   output logic                  div_zero
);

   // The dividend register shifts left each step and collects quotient bits in its LSB.
   logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
   logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
   logic [DIVISOR_W-1:0]  rem_q, rem_d;
   logic [DIVISOR_W:0]    trial;
   logic [DIVISOR_W-1:0]  diff;
   logic                  fits;
   logic                  dz_req;
   logic                  load, load_dz, shift, sub;

   always_comb begin
      trial = {rem_q, dvd_q[DIVIDEND_W-1]};
      fits  = (trial >= {1'b0, dvs_q});
      // When the trial fits, the true difference is below the divisor, so the low bits suffice.
      diff  = trial[DIVISOR_W-1:0] - dvs_q;
   end

`ifdef SEQ_DIVIDER_DIV_ZERO_CHECK_EN
   logic dz_q, dz_d;

   always_comb begin
      dz_req = (divisor == '0);
      dz_d   = dz_q;
      if (load) begin
         dz_d = 1'b0;
      end else if (load_dz) begin
         dz_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dz_q <= 1'b0;
      end else begin
         dz_q <= dz_d;
      end
   end

   assign div_zero = dz_q;
`else
   always_comb begin
      dz_req = 1'b0;
   end

   assign div_zero = 1'b0;
`endif

   always_comb begin
      dvd_d = dvd_q;
      dvs_d = dvs_q;
      rem_d = rem_q;
      if (load) begin
         dvd_d = dividend;
         dvs_d = divisor;
         rem_d = '0;
      end else if (load_dz) begin
         dvd_d = '1;
         dvs_d = divisor;
         rem_d = dividend[DIVISOR_W-1:0];
      end else if (shift) begin
         dvd_d = {dvd_q[DIVIDEND_W-2:0], sub};
         rem_d = sub ? diff : trial[DIVISOR_W-1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dvd_q <= '0;
         dvs_q <= '0;
         rem_q <= '0;
      end else begin
         dvd_q <= dvd_d;
         dvs_q <= dvs_d;
         rem_q <= rem_d;
      end
   end

   assign quotient  = dvd_q;
   assign remainder = rem_q;

   div_controller #(
      .DIVIDEND_W (DIVIDEND_W)
   ) u_ctrl (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .enable  (enable),
      .dz_req  (dz_req),
      .fits    (fits),
      .busy    (busy),
      .done    (done),
      .load    (load),
      .load_dz (load_dz),
      .shift   (shift),
      .sub     (sub)
   );

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: arithmetic reference model plus directed scenarios.
// Expectations follow SEQ_DIVIDER_DIV_ZERO_CHECK_EN when it is defined for the build.
module tb_seq_divider;

   localparam int DW = 8;
   localparam int VW = 4;
`ifdef SEQ_DIVIDER_DIV_ZERO_CHECK_EN
   localparam bit DZ_EN = 1'b1;
`else
   localparam bit DZ_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          enable;
   logic [DW-1:0] dividend;
   logic [VW-1:0] divisor;
   logic          busy;
   logic          done;
   logic [DW-1:0] quotient;
   logic [VW-1:0] remainder;
   logic          div_zero;

   int n_vec  = 0;
   int n_miss = 0;

   seq_divider #(.DIVIDEND_W(DW), .DIVISOR_W(VW)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .enable    (enable),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder),
      .div_zero  (div_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: operation modes, a step budget, and results from plain / and %.
   typedef enum int {M_IDLE, M_ITER, M_DONE} mstate_t;
   mstate_t       m_st   = M_IDLE;
   int            m_left = 0;
   logic [DW-1:0] m_q    = '0;
   logic [VW-1:0] m_r    = '0;
   logic          m_dz   = 1'b0;
   logic [DW-1:0] m_pq   = '0;
   logic [VW-1:0] m_pr   = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_st = M_IDLE; m_left = 0; m_q = '0; m_r = '0; m_dz = 1'b0;
      end else if (enable) begin
         if (m_st == M_ITER) begin
            m_left--;
            if (m_left == 0) begin
               m_st = M_DONE; m_q = m_pq; m_r = m_pr;
            end
         end else if (start) begin
            if (divisor == 0) begin
               m_pq = '1; m_pr = dividend[VW-1:0];
            end else begin
               m_pq = DW'(dividend / divisor); m_pr = VW'(dividend % divisor);
            end
            if (DZ_EN && divisor == 0) begin
               m_st = M_DONE; m_q = m_pq; m_r = m_pr; m_dz = 1'b1;
            end else begin
               m_st = M_ITER; m_left = DW; m_dz = 1'b0;
            end
         end else if (m_st == M_DONE) begin
            m_st = M_IDLE;
         end
      end
   end

   always @(negedge clk) begin
      check("busy", busy, m_st == M_ITER);
      check("done", done, m_st == M_DONE);
      if (m_st != M_ITER) begin
         check("quotient", quotient, m_q);
         check("remainder", remainder, m_r);
         check("div_zero", div_zero, m_dz);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic accept(input logic [DW-1:0] a, input logic [VW-1:0] b);
      start = 1'b1; enable = 1'b1; dividend = a; divisor = b;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(output int edges, output int busy_cnt);
      edges = 0; busy_cnt = 0;
      while (!done && edges < 50) begin
         if (busy) busy_cnt++;
         tick();
         edges++;
      end
   endtask

   int edges, bcnt, total;

   initial begin
      rst = 1'b1; start = 1'b0; enable = 1'b1; dividend = '0; divisor = '0;
      repeat (2) tick();
      check("rst_q", quotient, 0);
      check("rst_r", remainder, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_dz", div_zero, 0);
      rst = 1'b0;
      tick();

      // 200 / 7
      accept(8'd200, 4'd7);
      wait_done(edges, bcnt);
      check("lat_200_7", edges, 8);
      check("busy_cycles_200_7", bcnt, 8);
      check("q_200_7", quotient, 28);
      check("r_200_7", remainder, 4);
      check("dz_200_7", div_zero, 0);
      enable = 1'b0;
      repeat (3) tick();
      check("done_frozen", done, 1);
      enable = 1'b1;
      tick();
      check("done_to_idle", done, 0);
      check("q_held_idle", quotient, 28);

      // 255 / 15 then 13 / 14 back to back from DONE
      accept(8'd255, 4'd15);
      wait_done(edges, bcnt);
      check("lat_255_15", edges, 8);
      check("q_255_15", quotient, 17);
      check("r_255_15", remainder, 0);
      accept(8'd13, 4'd14);
      check("b2b_busy", busy, 1);
      check("b2b_done", done, 0);
      wait_done(edges, bcnt);
      check("lat_13_14", edges, 8);
      check("q_13_14", quotient, 0);
      check("r_13_14", remainder, 13);
      tick();

      // 156 / 0
      accept(8'd156, 4'd0);
      wait_done(edges, bcnt);
      check("lat_156_0", edges, DZ_EN ? 0 : 8);
      check("busy_cycles_156_0", bcnt, DZ_EN ? 0 : 8);
      check("q_156_0", quotient, 255);
      check("r_156_0", remainder, 12);
      check("dz_156_0", div_zero, DZ_EN ? 1 : 0);
      tick();

      // 100 / 3 with a 5-cycle enable stall and an ignored start pulse
      accept(8'd100, 4'd3);
      tick();
      start = 1'b1; dividend = 8'd7; divisor = 4'd1;
      tick();
      start = 1'b0;
      tick();
      enable = 1'b0;
      repeat (5) tick();
      check("stall_busy", busy, 1);
      enable = 1'b1;
      wait_done(edges, bcnt);
      total = 8 + edges;
      check("lat_stall", total, 13);
      check("q_100_3", quotient, 33);
      check("r_100_3", remainder, 1);
      tick();

      // 100 / 3 abandoned by reset mid-ITER, then 9 / 2
      accept(8'd100, 4'd3);
      repeat (3) tick();
      #2 rst = 1'b1;
      #1;
      check("arst_q", quotient, 0);
      check("arst_r", remainder, 0);
      check("arst_busy", busy, 0);
      check("arst_done", done, 0);
      check("arst_dz", div_zero, 0);
      tick();
      rst = 1'b0;
      repeat (10) tick();
      check("no_done_after_rst", done, 0);
      accept(8'd9, 4'd2);
      wait_done(edges, bcnt);
      check("lat_9_2", edges, 8);
      check("q_9_2", quotient, 4);
      check("r_9_2", remainder, 1);
      repeat (2) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, miscompares so far %0d", n_miss);
      $fatal(1);
   end

endmodule
